// File: rtl/kanagawa_prefetch_buffer_fifo.sv
// RAM-backed FIFO feeding a small register prefetch FIFO. Refill is driven only
// by registered state, so rdreq never reaches the RAM read enable.
module kanagawa_prefetch_buffer_fifo #(
  parameter int unsigned DEPTH              = 32,
  parameter int unsigned WIDTH              = 32,
  parameter int unsigned PREFETCH_DEPTH     = 3,
  parameter int unsigned ALMOSTFULL_ENTRIES = 0,
  parameter int unsigned USE_LUTRAM         = 0
) (
  input  logic                                           clock,
  input  logic                                           rst_n,
  input  logic                                           flush,
  input  logic                                           wrreq,
  input  logic [WIDTH-1:0]                               data,
  output logic                                           full,
  output logic                                           almost_full,
  output logic                                           overflow_out,
  input  logic                                           rdreq,
  output logic                                           empty,
  output logic [WIDTH-1:0]                               q,
  output logic                                           underflow_out,
  output logic [$clog2(DEPTH+PREFETCH_DEPTH+1)-1:0]      count
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned MC_W      = $clog2(DEPTH + 1);
  localparam int unsigned PC_W      = $clog2(PREFETCH_DEPTH + 1);
  localparam int unsigned CR_W      = PC_W + 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH + PREFETCH_DEPTH + 1);
  localparam int unsigned AF_THRESH = (ALMOSTFULL_ENTRIES >= DEPTH) ? 0 : DEPTH - ALMOSTFULL_ENTRIES;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MC_W-1:0]  mem_count_q, mem_count_d;
  logic [PC_W-1:0]  pf_count_q, pf_count_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             full_q, full_d, af_q, af_d, empty_q, empty_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH-1:0] pf_data_q [PREFETCH_DEPTH];
  logic [WIDTH-1:0] pf_data_d [PREFETCH_DEPTH];
  logic [WIDTH-1:0] ram_rd_q;
  logic             wr_acc_c, pop_c, issue_c, arrive_c;
  logic [PC_W-1:0]  arr_idx_c;

  // Next-state logic; flush overrides every other event.
  always_comb begin
    wr_acc_c  = wrreq & ~full_q & ~flush;
    pop_c     = rdreq & ~empty_q & ~flush;
    arrive_c  = inflight_q & ~flush;
    issue_c   = ~flush & (mem_count_q != '0) &
                ((CR_W'(pf_count_q) + CR_W'(inflight_q)) < CR_W'(PREFETCH_DEPTH));
    arr_idx_c = pf_count_q - PC_W'(pop_c);

    wr_ptr_d    = flush ? '0 : wr_ptr_q + PTR_W'(wr_acc_c);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + PTR_W'(issue_c);
    mem_count_d = flush ? '0 : mem_count_q + MC_W'(wr_acc_c) - MC_W'(issue_c);
    pf_count_d  = flush ? '0 : pf_count_q + PC_W'(arrive_c) - PC_W'(pop_c);
    count_d     = flush ? '0 : count_q + CNT_W'(wr_acc_c) - CNT_W'(pop_c);
    inflight_d  = issue_c;

    pf_data_d = pf_data_q;
    if (pop_c) begin
      for (int unsigned i = 0; i < PREFETCH_DEPTH - 1; i++) begin
        pf_data_d[i] = pf_data_q[i+1];
      end
    end
    if (arrive_c) begin
      for (int unsigned i = 0; i < PREFETCH_DEPTH; i++) begin
        if (PC_W'(i) == arr_idx_c) pf_data_d[i] = ram_rd_q;
      end
    end

    full_d  = (mem_count_d == MC_W'(DEPTH));
    af_d    = (mem_count_d >= MC_W'(AF_THRESH));
    empty_d = (pf_count_d == '0);
    ovf_d   = wrreq & full_q & ~flush;
    udf_d   = rdreq & empty_q & ~flush;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      pf_count_q  <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      full_q      <= 1'b0;
      af_q        <= (AF_THRESH == 0);
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      for (int unsigned i = 0; i < PREFETCH_DEPTH; i++) pf_data_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      pf_count_q  <= pf_count_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      full_q      <= full_d;
      af_q        <= af_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      pf_data_q   <= pf_data_d;
    end
  end

  // Storage array with registered read port; USE_LUTRAM only steers inference.
  if (USE_LUTRAM != 0) begin : g_lutram
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clock) begin
      if (wr_acc_c) mem_q[wr_ptr_q] <= data;
      if (issue_c)  ram_rd_q <= mem_q[rd_ptr_q];
    end
  end else begin : g_bram
    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clock) begin
      if (wr_acc_c) mem_q[wr_ptr_q] <= data;
      if (issue_c)  ram_rd_q <= mem_q[rd_ptr_q];
    end
  end

  assign full          = full_q;
  assign almost_full   = af_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = udf_q;
  assign empty         = empty_q;
  assign q             = pf_data_q[0];
  assign count         = count_q;

endmodule
